// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, state type and op-class helper shared by the MDU sequencer.
package mdu_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6
    } mdu_ctrl_e;

    typedef enum logic {IDLE, RUN} state_e;

    function automatic logic is_md_op(input logic [3:0] ctrl);
        return ctrl inside {MULT, MULTU, DIV, DIVU};
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational multiply/divide datapath producing the 64-bit {hi, lo} result.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  ctrl,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] old_hi,
    input  logic [31:0] old_lo,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic        sgn;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] prod;

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
    always_comb begin
        sgn      = ctrl == DIV;
        mag_a    = sgn && src_a[31] ? -src_a : src_a;
        mag_b    = sgn && src_b[31] ? -src_b : src_b;
        quo      = mag_b == '0 ? '0 : mag_a / mag_b;
        rem      = mag_b == '0 ? '0 : mag_a % mag_b;
        prod     = ctrl == MULT ? {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b}
                                : {32'd0, src_a} * {32'd0, src_b};
        {hi, lo} = (ctrl == MULT || ctrl == MULTU) ? prod
                 : src_b == '0 ? {old_hi, old_lo}
                 : {sgn && src_a[31] ? -rem : rem, sgn && (src_a[31] ^ src_b[31]) ? -quo : quo};
    end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MDU for EX; holds results pending for the op latency,
// then commits them to HI/LO while driving busy and the ID stall request.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = $clog2(DIV_LAT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  ctrl,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        id_mdu_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             accept;
    logic             commit;

    mdu_arith u_arith (
        .ctrl   (ctrl),
        .src_a  (srcA),
        .src_b  (srcB),
        .old_hi (HI),
        .old_lo (LO),
        .hi     (res_hi),
        .lo     (res_lo)
    );

    always_comb begin
        accept    = state == IDLE && start && is_md_op(ctrl);
        commit    = state == RUN && cnt == '0;
        state_nxt = accept ? RUN : commit ? IDLE : state;
        cnt_nxt   = accept ? ((ctrl == MULT || ctrl == MULTU) ? CNT_W'(MULT_LAT - 1) : CNT_W'(DIV_LAT - 1))
                  : (state == RUN && !commit) ? cnt - CNT_W'(1) : cnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
            end
            if (commit) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end else if (state == IDLE && start && ctrl == MTHI) begin
                HI <= srcA;
            end else if (state == IDLE && start && ctrl == MTLO) begin
                LO <= srcA;
            end
        end
    end

    assign busy  = state == RUN;
    assign stall = id_mdu_use & (busy | (start & is_md_op(ctrl)));

endmodule
